// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared types and helpers for the panel-side scanout sink.
//   RGB_W        : pixel width, {R,G,B} with 8 bits per channel
//   CH_W         : width of one colour channel
//   rgb_t        : packed pixel type
//   scan_state_t : scanout state machine encoding (IDLE, PRIME, SCAN)
//   cnt_width()  : bits needed to hold 0..n inclusive, so that a counter
//                  and all of its window boundaries share one width
// -----------------------------------------------------------------------------
package display_pkg;

    localparam int RGB_W = 24;
    localparam int CH_W  = RGB_W / 3;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        SCAN  = 2'd2
    } scan_state_t;

    // One extra code point beyond n-1 lets "end of window" constants equal to
    // the total period be represented without wrapping to zero.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// -----------------------------------------------------------------------------
// pixel_fifo
// Synchronous pixel FIFO with an occupancy count and registered read data.
//   clk       : clock
//   rst       : asynchronous active-high reset (pointers and count only)
//   push      : write push_data this cycle (ignored while full)
//   push_data : pixel to write
//   pop       : read the head entry this cycle (ignored while empty)
//   pop_data  : head entry captured on the cycle after a pop
//   count     : number of stored entries, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
// Storage is a plain array with a registered read port so it maps onto
// block RAM; a push into an empty FIFO is not visible to a same-cycle pop
// because empty comes from the registered count.
// -----------------------------------------------------------------------------
module pixel_fifo
    import display_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rgb_t                     push_data,
    input  logic                     pop,
    output rgb_t                     pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    rgb_t          mem [DEPTH];
    rgb_t          pop_data_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == DEPTH_L);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage and read register carry no reset: contents are qualified by
    // count, and leaving them unreset keeps the array mappable to block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (pop_ok) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = pop_data_reg;
    assign count    = count_reg;

endmodule

// File: rtl/display_scanout_sink.sv
// -----------------------------------------------------------------------------
// display_scanout_sink
// Panel-side receiver: buffers an RGB pixel stream in a small FIFO and scans
// it out with a raster timing generator.
//   clk          : clock
//   rst          : asynchronous active-high reset
//   enable       : scanout enable; low returns to IDLE (FIFO retained)
//   pix_rgb      : incoming pixel {R,G,B}
//   pix_valid    : pixel present this cycle (never held by the sender)
//   pix_ready    : FIFO has room this cycle
//   panel_rgb    : panel pixel data (0 outside active video or on underrun)
//   panel_de     : data enable
//   panel_hsync  : horizontal sync, active-high
//   panel_vsync  : vertical sync, active-high
//   frame_start  : pulse with the first panel_de of each frame
//   overflow     : sticky, a pixel arrived while the FIFO was full
//   underrun     : sticky, FIFO was empty during active video
//   busy         : state machine is not IDLE
// Pipeline: counters -> stage 1 (timing decode + FIFO read register) ->
// panel output register, so the first pixel appears two cycles after the
// PRIME->SCAN transition.
// -----------------------------------------------------------------------------
module display_scanout_sink
    import display_pkg::*;
#(
    parameter int H_ACTIVE    = 8,
    parameter int H_FRONT     = 1,
    parameter int H_SYNC      = 2,
    parameter int H_BACK      = 1,
    parameter int V_ACTIVE    = 4,
    parameter int V_FRONT     = 1,
    parameter int V_SYNC      = 1,
    parameter int V_BACK      = 1,
    parameter int FIFO_DEPTH  = 8,
    parameter int PRIME_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [RGB_W-1:0] pix_rgb,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [RGB_W-1:0] panel_rgb,
    output logic             panel_de,
    output logic             panel_hsync,
    output logic             panel_vsync,
    output logic             frame_start,
    output logic             overflow,
    output logic             underrun,
    output logic             busy
);

    // ------------------------------------------------------------------
    // Timing constants, all sized to the counter widths
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = cnt_width(H_TOTAL);
    localparam int VW      = cnt_width(V_TOTAL);
    localparam int CW      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic [CW-1:0] PRIME_L    = CW'(PRIME_LEVEL);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    scan_state_t   state_reg;
    logic [HW-1:0] h_cnt_reg;
    logic [VW-1:0] v_cnt_reg;

    logic          s1_de_reg;
    logic          s1_hs_reg;
    logic          s1_vs_reg;
    logic          s1_fs_reg;
    logic          s1_pop_reg;

    logic          panel_de_reg;
    logic          panel_hsync_reg;
    logic          panel_vsync_reg;
    logic          frame_start_reg;
    logic          overflow_reg;
    logic          underrun_reg;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    rgb_t          fifo_rd_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;

    assign pix_ready = !fifo_full;
    assign fifo_push = pix_valid && pix_ready;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pix_rgb),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Timing decode from the current counters
    // ------------------------------------------------------------------
    logic in_scan;
    logic scan_active;
    logic hsync_now;
    logic vsync_now;
    logic frame_first;
    logic starve;

    // enable is folded in so that the cycle in which enable drops neither
    // pops a pixel nor flags an underrun.
    assign in_scan     = (state_reg == SCAN) && enable;
    assign scan_active = in_scan && (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    assign hsync_now   = in_scan && (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
    assign vsync_now   = in_scan && (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
    assign frame_first = scan_active && (h_cnt_reg == '0) && (v_cnt_reg == '0);
    assign fifo_pop    = scan_active && !fifo_empty;
    assign starve      = scan_active && fifo_empty;

    // ------------------------------------------------------------------
    // Scanout state machine and raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (!enable) begin
            state_reg <= IDLE;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    state_reg <= PRIME;
                end
                PRIME: begin
                    if (fifo_count >= PRIME_L) begin
                        state_reg <= SCAN;
                        h_cnt_reg <= '0;
                        v_cnt_reg <= '0;
                    end
                end
                SCAN: begin
                    if (h_cnt_reg == H_LAST) begin
                        h_cnt_reg <= '0;
                        v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
                    end else begin
                        h_cnt_reg <= h_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Stage 1 and panel output registers (control)
    // Dropping enable flushes both stages so the panel goes dark on the
    // very next cycle rather than draining the pipeline.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_de_reg       <= 1'b0;
            s1_hs_reg       <= 1'b0;
            s1_vs_reg       <= 1'b0;
            s1_fs_reg       <= 1'b0;
            s1_pop_reg      <= 1'b0;
            panel_de_reg    <= 1'b0;
            panel_hsync_reg <= 1'b0;
            panel_vsync_reg <= 1'b0;
            frame_start_reg <= 1'b0;
        end else if (!enable) begin
            s1_de_reg       <= 1'b0;
            s1_hs_reg       <= 1'b0;
            s1_vs_reg       <= 1'b0;
            s1_fs_reg       <= 1'b0;
            s1_pop_reg      <= 1'b0;
            panel_de_reg    <= 1'b0;
            panel_hsync_reg <= 1'b0;
            panel_vsync_reg <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            s1_de_reg       <= scan_active;
            s1_hs_reg       <= hsync_now;
            s1_vs_reg       <= vsync_now;
            s1_fs_reg       <= frame_first;
            s1_pop_reg      <= fifo_pop;
            panel_de_reg    <= s1_de_reg;
            panel_hsync_reg <= s1_hs_reg;
            panel_vsync_reg <= s1_vs_reg;
            frame_start_reg <= s1_fs_reg;
        end
    end

    // ------------------------------------------------------------------
    // Panel pixel data, one register per colour channel. A starved active
    // cycle has s1_pop_reg low and therefore shows black.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [CH_W-1:0] chan_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    chan_reg <= '0;
                end else if (!enable || !s1_pop_reg) begin
                    chan_reg <= '0;
                end else begin
                    chan_reg <= fifo_rd_data[gi*CH_W +: CH_W];
                end
            end

            assign panel_rgb[gi*CH_W +: CH_W] = chan_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sticky status flags, cleared only by reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            if (pix_valid && !pix_ready) begin
                overflow_reg <= 1'b1;
            end
            if (starve) begin
                underrun_reg <= 1'b1;
            end
        end
    end

    assign panel_de    = panel_de_reg;
    assign panel_hsync = panel_hsync_reg;
    assign panel_vsync = panel_vsync_reg;
    assign frame_start = frame_start_reg;
    assign overflow    = overflow_reg;
    assign underrun    = underrun_reg;

endmodule

// File: tb/tb_display_scanout_sink.sv
// -----------------------------------------------------------------------------
// tb_display_scanout_sink
// Directed bench for display_scanout_sink with default parameters
// (8x4 active, H_TOTAL 12, V_TOTAL 7, FIFO depth 8, prime level 4).
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_display_scanout_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] pix_rgb;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] panel_rgb;
    logic        panel_de;
    logic        panel_hsync;
    logic        panel_vsync;
    logic        frame_start;
    logic        overflow;
    logic        underrun;
    logic        busy;

    int checks = 0;
    int errors = 0;

    display_scanout_sink dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pix_rgb     (pix_rgb),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .panel_rgb   (panel_rgb),
        .panel_de    (panel_de),
        .panel_hsync (panel_hsync),
        .panel_vsync (panel_vsync),
        .frame_start (frame_start),
        .overflow    (overflow),
        .underrun    (underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Ingress vector: one cycle of sender activity plus what must be seen.
    typedef struct {
        logic        valid;
        logic [23:0] rgb;
        logic        exp_ready;  // pix_ready before the edge
        logic        exp_ovf;    // overflow after the edge
    } ing_vec_t;

    // Scanout vector: one output cycle of the first line.
    typedef struct {
        logic        exp_de;
        logic [23:0] exp_rgb;
        logic        chk_und;
        logic        exp_und;
    } out_vec_t;

    ing_vec_t    ing_tab [12];
    out_vec_t    line_tab [9];
    logic [23:0] cap [9];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check24(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1 (  {tag, "_ready"},  pix_ready,   1'b1);
        check24(  {tag, "_rgb"},    panel_rgb,   24'h0);
        check1 (  {tag, "_de"},     panel_de,    1'b0);
        check1 (  {tag, "_hsync"},  panel_hsync, 1'b0);
        check1 (  {tag, "_vsync"},  panel_vsync, 1'b0);
        check1 (  {tag, "_fs"},     frame_start, 1'b0);
        check1 (  {tag, "_ovf"},    overflow,    1'b0);
        check1 (  {tag, "_und"},    underrun,    1'b0);
        check1 (  {tag, "_busy"},   busy,        1'b0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        pix_valid = 1'b0;
        pix_rgb   = 24'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Watchdog: every wait below is bounded, this only guards the unexpected.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nxt;
        int t;
        int h;
        int ln;
        int ncap;
        int lat;
        logic        e_de;
        logic [23:0] e_rgb;

        // ---------------- tables ----------------
        // 12 back-to-back pixels into an idle sink: 8 fit, the last 4 drop.
        for (int i = 0; i < 12; i++) begin
            ing_tab[i].valid     = 1'b1;
            ing_tab[i].rgb       = 24'h000100 + 24'(i);
            ing_tab[i].exp_ready = (i < 8);
            ing_tab[i].exp_ovf   = (i >= 8);
        end
        // First line after priming with exactly 4 pixels.
        line_tab[0] = '{1'b1, 24'h000200, 1'b1, 1'b0};
        line_tab[1] = '{1'b1, 24'h000201, 1'b0, 1'b0};
        line_tab[2] = '{1'b1, 24'h000202, 1'b0, 1'b0};
        line_tab[3] = '{1'b1, 24'h000203, 1'b0, 1'b0};
        line_tab[4] = '{1'b1, 24'h000000, 1'b0, 1'b0};
        line_tab[5] = '{1'b1, 24'h000000, 1'b0, 1'b0};
        line_tab[6] = '{1'b1, 24'h000000, 1'b0, 1'b0};
        line_tab[7] = '{1'b1, 24'h000000, 1'b1, 1'b1};
        line_tab[8] = '{1'b0, 24'h000000, 1'b1, 1'b1};

        // ---------------- reset values ----------------
        do_reset();
        check_reset_values("reset");

        // ---------------- enable with no pixels ----------------
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check1 ("prime_busy",  busy,      1'b1);
        check1 ("prime_de",    panel_de,  1'b0);
        check1 ("prime_ready", pix_ready, 1'b1);
        check24("prime_rgb",   panel_rgb, 24'h0);
        $display("step prime: busy=%0b de=%0b ready=%0b", busy, panel_de, pix_ready);

        // ---------------- 32 pixels, one full frame ----------------
        // The source offers a new pixel every cycle the sink has room.
        // Pixel 4 lands at edge 4, SCAN at edge 5, first DE after edge 7.
        nxt = 1;
        for (int cyc = 0; cyc <= 7 + 83; cyc++) begin
            if (cyc == 6) begin
                check1("f1_de_before_start", panel_de, 1'b0);
            end
            if (cyc >= 7) begin
                t     = cyc - 7;
                h     = t % 12;
                ln    = t / 12;
                e_de  = (h < 8) && (ln < 4);
                e_rgb = e_de ? 24'(ln * 8 + h + 1) : 24'h0;
                check1 ($sformatf("f1_de t=%0d", t),    panel_de,    e_de);
                check24($sformatf("f1_rgb t=%0d", t),   panel_rgb,   e_rgb);
                check1 ($sformatf("f1_hsync t=%0d", t), panel_hsync, (h == 9) || (h == 10));
                check1 ($sformatf("f1_vsync t=%0d", t), panel_vsync, ln == 5);
                check1 ($sformatf("f1_fs t=%0d", t),    frame_start, t == 0);
                if (t == 60) begin
                    check1("f1_underrun", underrun, 1'b0);
                end
            end
            if (nxt <= 32 && pix_ready) begin
                pix_valid = 1'b1;
                pix_rgb   = 24'(nxt);
                $display("push pixel %06h", pix_rgb);
                nxt++;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        check_int("f1_pixels_sent", nxt - 1, 32);
        check1   ("f1_overflow",    overflow, 1'b0);

        // ---------------- overflow with enable low ----------------
        do_reset();
        enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            pix_valid = ing_tab[i].valid;
            pix_rgb   = ing_tab[i].rgb;
            check1($sformatf("ing_ready i=%0d", i), pix_ready, ing_tab[i].exp_ready);
            @(negedge clk);
            check1($sformatf("ing_ovf i=%0d", i), overflow, ing_tab[i].exp_ovf);
            $display("ingress vec %0d: rgb=%06h ready=%0b ovf=%0b", i, ing_tab[i].rgb, pix_ready, overflow);
        end
        pix_valid = 1'b0;
        check1("ing_ready_after", pix_ready, 1'b0);
        enable = 1'b1;
        ncap   = 0;
        for (int c = 0; c < 60 && ncap < 9; c++) begin
            @(negedge clk);
            if (panel_de) begin
                cap[ncap] = panel_rgb;
                ncap++;
            end
        end
        check_int("ing_captured", ncap, 9);
        for (int i = 0; i < 8; i++) begin
            check24($sformatf("ing_pixel %0d", i), cap[i], 24'h000100 + 24'(i));
        end
        check24("ing_dropped_absent", cap[8], 24'h0);
        check1 ("ing_underrun",       underrun, 1'b1);

        // ---------------- prime with 4 then starve ----------------
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_rgb   = 24'h000200 + 24'(i);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            check1 ($sformatf("starve_de t=%0d", i),  panel_de,  line_tab[i].exp_de);
            check24($sformatf("starve_rgb t=%0d", i), panel_rgb, line_tab[i].exp_rgb);
            if (line_tab[i].chk_und) begin
                check1($sformatf("starve_und t=%0d", i), underrun, line_tab[i].exp_und);
            end
            $display("starve vec %0d: de=%0b rgb=%06h und=%0b", i, panel_de, panel_rgb, underrun);
            @(negedge clk);
        end

        // ---------------- drop enable at h_cnt 3 of line 1 ----------------
        do_reset();
        enable = 1'b1;
        @(negedge clk);
        nxt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (nxt < 16 && pix_ready) begin
                pix_valid = 1'b1;
                pix_rgb   = 24'h000300 + 24'(nxt);
                nxt++;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
        end
        pix_valid = 1'b0;
        // Counters are at line 1, h 3 now; output shows line 1, h 1.
        check1 ("dis_de_before",  panel_de,  1'b1);
        check24("dis_rgb_before", panel_rgb, 24'h000309);
        enable = 1'b0;
        @(negedge clk);
        check24("dis_rgb",   panel_rgb,   24'h0);
        check1 ("dis_de",    panel_de,    1'b0);
        check1 ("dis_hsync", panel_hsync, 1'b0);
        check1 ("dis_vsync", panel_vsync, 1'b0);
        check1 ("dis_fs",    frame_start, 1'b0);
        check1 ("dis_busy",  busy,        1'b0);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        lat    = 0;
        while (!panel_de && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_int("reen_latency",   lat,       4);
        check1   ("reen_busy",      busy,      1'b1);
        check24  ("reen_first_rgb", panel_rgb, 24'h00030B);
        @(negedge clk);
        check24  ("reen_second_rgb", panel_rgb, 24'h00030C);
        repeat (8) @(negedge clk);
        check1   ("reen_underrun",   underrun,  1'b1);

        // ---------------- asynchronous reset mid-frame ----------------
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
